// File: rtl/iterative_alu_if.sv
// Request/result handshake bundle for iterative_alu.
// The unit (slave) accepts operations and returns a registered result.
interface iterative_alu_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ALUControl;
    logic [DATA_W-1:0] SrcA;
    logic [DATA_W-1:0] SrcB;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: one-cycle arithmetic/logic ops, shifter moving one bit per clock.
// Optional feature macro ALU_SLTU_EN: code 4'b0011 becomes unsigned set-less-than.
module iterative_alu (
    input  logic           clk,
    input  logic           reset,
    iterative_alu_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_SUB  = 4'b1000;
    localparam logic [CTRL_W-1:0] OP_SLL  = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_SLT  = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_SRA  = 4'b0101;
    localparam logic [CTRL_W-1:0] OP_SRL  = 4'b1101;
    localparam logic [CTRL_W-1:0] OP_OR   = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_AND  = 4'b0111;
`ifdef ALU_SLTU_EN
    localparam logic [CTRL_W-1:0] OP_SLTU = 4'b0011;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_t;

    state_t              state_q, state_d;
    shift_t              kind_q, kind_d, kind_sel;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0]  count_q, count_d, shamt;
    logic                is_shift;
    logic                in_ready_q, out_valid_q;

    // One-bit shift step; the accept edge performs the first step itself.
    function automatic logic [DATA_W-1:0] shift1(input shift_t k, input logic [DATA_W-1:0] v);
        case (k)
            SH_SRA:  shift1 = {v[DATA_W-1], v[DATA_W-1:1]};
            SH_SRL:  shift1 = {1'b0, v[DATA_W-1:1]};
            default: shift1 = {v[DATA_W-2:0], 1'b0};
        endcase
    endfunction

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        kind_d   = kind_q;
        kind_sel = SH_SLL;
        is_shift = 1'b0;
        shamt    = bus.SrcB[SHAMT_W-1:0];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.ALUControl)
                        OP_ADD:  result_d = bus.SrcA + bus.SrcB;
                        OP_SUB:  result_d = bus.SrcA - bus.SrcB;
                        OP_SLT:  result_d = DATA_W'($signed(bus.SrcA) < $signed(bus.SrcB));
`ifdef ALU_SLTU_EN
                        OP_SLTU: result_d = DATA_W'(bus.SrcA < bus.SrcB);
`endif
                        OP_XOR:  result_d = bus.SrcA ^ bus.SrcB;
                        OP_OR:   result_d = bus.SrcA | bus.SrcB;
                        OP_AND:  result_d = bus.SrcA & bus.SrcB;
                        OP_SLL:  begin is_shift = 1'b1; kind_sel = SH_SLL; end
                        OP_SRL:  begin is_shift = 1'b1; kind_sel = SH_SRL; end
                        OP_SRA:  begin is_shift = 1'b1; kind_sel = SH_SRA; end
                        default: result_d = '0;
                    endcase

                    if (!is_shift) begin
                        state_d = DONE;
                    end else if (shamt == '0) begin
                        result_d = bus.SrcA;
                        state_d  = DONE;
                    end else begin
                        kind_d   = kind_sel;
                        result_d = shift1(kind_sel, bus.SrcA);
                        count_d  = shamt - SHAMT_W'(1);
                        state_d  = (shamt == SHAMT_W'(1)) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                result_d = shift1(kind_q, result_q);
                count_d  = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and handshake registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            kind_q      <= SH_SLL;
            result_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            result_q    <= result_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = (result_q == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed table, stall/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_iterative_alu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    iterative_alu_if alu_if ();

    iterative_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (alu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: operation semantics from the opcode table, plain arithmetic.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return 32'($signed(a) >>> sh);
            4'b1101: return a >> sh;
            4'b0110: return a | b;
            4'b0111: return a & b;
`ifdef ALU_SLTU_EN
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'b0001 || c == 4'b0101 || c == 4'b1101)
            return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
        return 1;
    endfunction

    // Issue one op from just after a rising edge, wait (bounded) for the result, consume it.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        int lat;
        alu_if.ALUControl = c;
        alu_if.SrcA       = a;
        alu_if.SrcB       = b;
        alu_if.in_valid   = 1'b1;
        alu_if.out_ready  = 1'b1;
        @(posedge clk); #1;
        alu_if.in_valid = 1'b0;
        lat = 1;
        while (!alu_if.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " result"}, alu_if.ALUResult, exp);
        check({name, " zero"}, 32'(alu_if.Zero), 32'(exp == 32'd0));
        @(posedge clk); #1;
        check({name, " idle after consume"}, 32'({alu_if.in_ready, alu_if.out_valid}), 32'h2);
    endtask

    initial begin
        int never_valid;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        checks = 0;
        errors = 0;
        alu_if.in_valid   = 1'b0;
        alu_if.ALUControl = 4'h0;
        alu_if.SrcA       = 32'h0;
        alu_if.SrcB       = 32'h0;
        alu_if.out_ready  = 1'b1;

        vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[1]  = '{4'b0101, 32'h8000_0000, 32'd4,         32'hF800_0000, 4};
        vecs[2]  = '{4'b1101, 32'h8000_0000, 32'd4,         32'h0800_0000, 4};
        vecs[3]  = '{4'b0010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1};
        vecs[4]  = '{4'b0011, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[5]  = '{4'b0001, 32'h0000_0001, 32'd31,        32'h8000_0000, 31};
        vecs[6]  = '{4'b0001, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1};
        vecs[7]  = '{4'b0101, 32'hF000_0000, 32'd1,         32'hF800_0000, 1};
        vecs[8]  = '{4'b0100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1};
        vecs[9]  = '{4'b0110, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1};
        vecs[10] = '{4'b0111, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1};
        vecs[11] = '{4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};
        vecs[12] = '{4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1};
        vecs[13] = '{4'b1101, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 31};
        vecs[14] = '{4'b0101, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 31};
        vecs[15] = '{4'b0010, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 1};

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(alu_if.in_ready), 32'd1);
        check("reset out_valid", 32'(alu_if.out_valid), 32'd0);
        check("reset result", alu_if.ALUResult, 32'd0);
        check("reset zero", 32'(alu_if.Zero), 32'd1);
        reset = 1'b0;

        // Directed table; first op is accepted on the first edge after release
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Result held under back-pressure; new requests ignored while DONE
        alu_if.out_ready  = 1'b0;
        alu_if.ALUControl = 4'b1000;
        alu_if.SrcA       = 32'd5;
        alu_if.SrcB       = 32'd5;
        alu_if.in_valid   = 1'b1;
        @(posedge clk); #1;
        check("stall first valid", 32'(alu_if.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            alu_if.ALUControl = 4'b0000;
            alu_if.SrcA       = 32'd7;
            alu_if.SrcB       = 32'd8;
            alu_if.in_valid   = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stall%0d valid/ready", i), 32'({alu_if.out_valid, alu_if.in_ready}), 32'h2);
            check($sformatf("stall%0d result", i), alu_if.ALUResult, 32'd0);
            check($sformatf("stall%0d zero", i), 32'(alu_if.Zero), 32'd1);
        end
        alu_if.in_valid  = 1'b0;
        alu_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall consumed", 32'({alu_if.in_ready, alu_if.out_valid}), 32'h2);
        check("stall no new op", alu_if.ALUResult, 32'd0);

        // Reset in the middle of a long shift abandons it
        alu_if.ALUControl = 4'b0001;
        alu_if.SrcA       = 32'd1;
        alu_if.SrcB       = 32'd31;
        alu_if.in_valid   = 1'b1;
        @(posedge clk); #1;
        alu_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-shift not valid", 32'(alu_if.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("async reset result", alu_if.ALUResult, 32'd0);
        check("async reset ready/valid", 32'({alu_if.in_ready, alu_if.out_valid}), 32'h2);
        check("async reset zero", 32'(alu_if.Zero), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        never_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (alu_if.out_valid) never_valid++;
        end
        check("abandoned shift delivered", 32'(never_valid), 32'd0);
        check("ready after reset", 32'(alu_if.in_ready), 32'd1);
        run_op("post-reset add", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

        // Random operations against the reference model
        for (int i = 0; i < 200; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (($urandom % 4) == 0) ra = ra >> ($urandom % 32);
            run_op($sformatf("rand%0d op%h", i, rc), rc, ra, rb, model(rc, ra, rb), model_lat(rc, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  operation request valid.
REQ-004 SHALL have port: in_ready  output  1  unit can accept a request (high only in IDLE).
REQ-005 SHALL have port: ALUControl  input  4  operation code, sampled on accept.
REQ-006 SHALL have port: SrcA  input  32  first operand, sampled on accept.
REQ-007 SHALL have port: SrcB  input  32  second operand / shift amount, sampled on accept.
REQ-008 SHALL have port: out_valid  output  1  ALUResult/Zero valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: ALUResult  output  32  registered result.
REQ-011 SHALL have port: Zero  output  1  high when ALUResult == 0 (combinational from result register).

Function
REQ-012 SHALL decode ALUControl: 0000 add, 1000 sub, 0001 sll, 0010 slt (signed), 0100 xor, 0101 sra, 1101 srl, 0110 or, 0111 and; 0011 per REQ-029/030.
REQ-013 SHALL treat every other code as illegal: result 32'h0, handled as a 1-cycle op.
REQ-014 SHALL accept a request when in_valid && in_ready at a rising edge; operands and code latched in that cycle.
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1, out_valid=0; on accept of non-shift op -> DONE with result written; on accept of shift op -> SHIFT, or DONE directly when shamt==0 (result = SrcA).
REQ-017 SHIFT: shift working register by exactly 1 bit per cycle, decrementing a 5-bit count from SrcB[4:0]; -> DONE on the cycle the count reaches zero; upper SrcB bits ignored.
REQ-018 SHALL give sra arithmetic fill (replicate bit 31), srl/sll zero fill.
REQ-019 Latency from accept edge to out_valid high: 1 cycle for non-shift/illegal/shamt 0; 1+shamt cycles... precisely shamt cycles for shamt>=1 (one edge per bit shifted).
REQ-020 DONE: out_valid=1, in_ready=0; ALUResult and Zero SHALL hold stable until out_valid && out_ready at an edge, then -> IDLE.
REQ-021 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE).
REQ-022 add/sub SHALL wrap modulo 2^32; no carry/overflow outputs.
REQ-023 slt SHALL return 32'h1 if signed SrcA < signed SrcB else 32'h0.
REQ-024 in_valid, ALUControl, SrcA, SrcB SHALL be ignored outside IDLE.
REQ-025 ALUResult SHALL change only on accept (non-shift), each SHIFT step, or reset; out_valid gates its meaning.

Reset
REQ-026 reset high SHALL immediately (asynchronously) force IDLE, ALUResult=0, shift count=0, out_valid=0, in_ready=1, Zero=1.
REQ-027 reset mid-SHIFT or in DONE SHALL abandon the operation; no result is delivered after release.
REQ-028 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 With macro ALU_SLTU_EN defined, code 0011 SHALL be sltu: 32'h1 if unsigned SrcA < unsigned SrcB else 32'h0, 1-cycle op.
REQ-030 Without ALU_SLTU_EN, code 0011 SHALL be illegal per REQ-013 (result 0, Zero=1); all other behaviour identical.

Verification
REQ-031 add 32'hFFFF_FFFF + 32'h1, out_ready=1 -> out_valid 1 cycle after accept, ALUResult=0, Zero=1, back to IDLE next edge.
REQ-032 sra SrcA=32'h8000_0000, SrcB=32'd4 -> out_valid exactly 4 cycles after accept, ALUResult=32'hF800_0000; srl same operands -> 32'h0800_0000.
REQ-033 slt SrcA=32'hFFFF_FFFE (-2), SrcB=1 -> 32'h1; with ALU_SLTU_EN, code 0011 same operands -> 32'h0; without macro -> 32'h0 after 1 cycle.
REQ-034 sub 5-5 with out_ready=0 for 3 cycles -> out_valid held, ALUResult=0, Zero=1 stable, in_ready=0; new in_valid ignored; consumed on 4th cycle.
REQ-035 sll SrcA=1, SrcB=32'd31, reset pulsed 10 cycles after accept -> out_valid never asserts, ALUResult=0, in_ready=1 after release; next add 2+3 -> 32'd5.
